program_sequencer: RTL and testbench

Instruction-fetch address generator for the 8-bit microprocessor core. It drives `pm_addr` into program memory, whose output becomes `next_instr` for the instruction decoder. It consumes the decoder's `jmp`, `jmp_nz` and `ir_nibble` outputs to steer fetch. It also provides a halt/step/breakpoint debug controller and a count of executed instructions.

---
 rtl/program_sequencer.sv | 173 +++++++++++++++++
 tb/tb_program_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Purpose  : Instruction-fetch address generator for the 8-bit core. Produces
//            the program memory address, tracks the address of the
//            instruction held in IR, steers fetch on JUMP / CONDITIONAL_JUMP,
//            and provides a halt / single-step / breakpoint debug controller
//            plus a count of executed instructions.
// Ports    :
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   sync_reset   in   synchronous functional reset (active high)
//   jmp          in   unconditional jump in IR
//   jmp_nz       in   conditional jump in IR
//   ir_nibble    in   [3:0] jump target page
//   dont_jmp     in   ALU zero flag, suppresses a conditional jump
//   halt_req     in   debug halt request (pulse)
//   step_req     in   debug single-step request (pulse)
//   resume_req   in   debug resume request (pulse)
//   bp_en        in   breakpoint enable
//   bp_addr      in   [7:0] breakpoint fetch address
//   cnt_clr      in   synchronous clear of instr_count
//   pm_addr      out  [7:0] program memory address (combinational)
//   pc           out  [7:0] address of instruction currently in IR
//   stall        out  suppress effects of the current IR
//   halted       out  debug controller is halted
//   instr_count  out  [15:0] executed instruction count
// Revision : 1.0  initial release
// ============================================================================
module program_sequencer #(
    parameter logic [7:0] RESET_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync_reset,
    input  logic        jmp,
    input  logic        jmp_nz,
    input  logic [3:0]  ir_nibble,
    input  logic        dont_jmp,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        resume_req,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic        cnt_clr,
    output logic [7:0]  pm_addr,
    output logic [7:0]  pc,
    output logic        stall,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    state_t      state_q;
    logic        halted_q;
    logic        boot_q;
    logic [7:0]  pc_q;
    logic [7:0]  pc_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    logic        w_exec;
    logic        w_taken;
    logic        w_bp_hit;
    logic [7:0]  w_target;
    logic [7:0]  w_pc_inc;

    assign w_exec   = (state_q != ST_HALTED) && !sync_reset;
    assign w_taken  = w_exec && (jmp || (jmp_nz && !dont_jmp));
    assign w_target = {ir_nibble, 4'h0};
    assign w_pc_inc = pc_q + 8'd1;

    // Fetch address mux. boot_q is low only for the first cycle after
    // reset_n is released: IR is not yet loaded, so the reset address is
    // presented again and pc picks it up on the first edge.
    always_comb begin
        pc_d = w_pc_inc;
        if (!reset_n) begin
            pc_d = RESET_ADDR;
        end else if (sync_reset) begin
            pc_d = RESET_ADDR;
        end else if (!boot_q) begin
            pc_d = RESET_ADDR;
        end else if (state_q == ST_HALTED) begin
            pc_d = pc_q;
        end else if (w_taken) begin
            pc_d = w_target;
        end
    end

    assign pm_addr  = pc_d;
    assign w_bp_hit = bp_en && (pc_d == bp_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RESET_ADDR;
            boot_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            boot_q <= 1'b1;
        end
    end

    // Debug FSM. halted_q mirrors the next state so stall/halted come
    // straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else if (sync_reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req || w_bp_hit) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    // Resume takes precedence over a simultaneous step.
                    if (resume_req) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end else if (step_req) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                    end
                end
                ST_STEP: begin
                    // Exactly one instruction executes; breakpoints ignored.
                    state_q  <= ST_HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Executed-instruction counter; survives sync_reset.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = 16'h0000;
        end else if (w_exec) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign stall       = halted_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Purpose  : Directed self-checking bench for program_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_program_sequencer;

    logic        clk;
    logic        reset_n;
    logic        sync_reset;
    logic        jmp;
    logic        jmp_nz;
    logic [3:0]  ir_nibble;
    logic        dont_jmp;
    logic        halt_req;
    logic        step_req;
    logic        resume_req;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic        cnt_clr;
    logic [7:0]  pm_addr;
    logic [7:0]  pc;
    logic        stall;
    logic        halted;
    logic [15:0] instr_count;

    int checks;
    int errors;

    program_sequencer #(.RESET_ADDR(8'h00)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sync_reset  (sync_reset),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .ir_nibble   (ir_nibble),
        .dont_jmp    (dont_jmp),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .resume_req  (resume_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cnt_clr     (cnt_clr),
        .pm_addr     (pm_addr),
        .pc          (pc),
        .stall       (stall),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1ns after the rising edge; checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_async_reset();
        tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sync_reset = 0; jmp = 0; jmp_nz = 0; ir_nibble = 0; dont_jmp = 0;
        halt_req = 0; step_req = 0; resume_req = 0; bp_en = 0; bp_addr = 0;
        cnt_clr = 0;
        #3;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
        checks++; if (pm_addr !== 8'h00) begin errors++; $display("FAIL reset_pm got %h exp 00", pm_addr); end
        checks++; if (instr_count !== 16'h0000) begin errors++; $display("FAIL reset_cnt got %h exp 0000", instr_count); end
        checks++; if ({halted, stall} !== 2'b00) begin errors++; $display("FAIL reset_halt got %b exp 00", {halted, stall}); end
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
    endtask

    // Cycle i after release: pm_addr = i mod 256, pc = i-1, count = i.
    task automatic test_increment();
        logic [7:0] exp_pc;
        for (int i = 0; i < 260; i++) begin
            exp_pc = (i == 0) ? 8'h00 : 8'(i - 1);
            checks++; if (pm_addr !== 8'(i)) begin errors++; $display("FAIL inc_pm[%0d] got %h exp %h", i, pm_addr, 8'(i)); end
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL inc_pc[%0d] got %h exp %h", i, pc, exp_pc); end
            checks++; if (instr_count !== 16'(i)) begin errors++; $display("FAIL inc_cnt[%0d] got %h exp %h", i, instr_count, 16'(i)); end
            tick();
        end
    endtask

    task automatic test_jump();
        sync_reset = 1'b1;
        #1;
        checks++; if (pm_addr !== 8'h00) begin errors++; $display("FAIL sr_pm got %h exp 00", pm_addr); end
        tick();
        sync_reset = 1'b0;
        repeat (18) tick();
        checks++; if (pc !== 8'h12) begin errors++; $display("FAIL jmp_pre_pc got %h exp 12", pc); end
        jmp = 1'b1; ir_nibble = 4'h5;
        #1;
        checks++; if (pm_addr !== 8'h50) begin errors++; $display("FAIL jmp_pm got %h exp 50", pm_addr); end
        tick();
        jmp = 1'b0;
        #1;
        checks++; if (pc !== 8'h50) begin errors++; $display("FAIL jmp_pc got %h exp 50", pc); end
        checks++; if (pm_addr !== 8'h51) begin errors++; $display("FAIL jmp_next_pm got %h exp 51", pm_addr); end
    endtask

    task automatic test_cond_jump();
        jmp_nz = 1'b1; ir_nibble = 4'hA; dont_jmp = 1'b1;
        #1;
        checks++; if (pm_addr !== 8'h51) begin errors++; $display("FAIL cj_not_taken got %h exp 51", pm_addr); end
        dont_jmp = 1'b0;
        #1;
        checks++; if (pm_addr !== 8'hA0) begin errors++; $display("FAIL cj_taken got %h exp a0", pm_addr); end
        tick();
        jmp_nz = 1'b0;
        #1;
        checks++; if (pc !== 8'hA0) begin errors++; $display("FAIL cj_pc got %h exp a0", pc); end
    endtask

    task automatic test_breakpoint();
        bp_en = 1'b1; bp_addr = 8'h05;
        do_async_reset();
        repeat (5) tick();
        checks++; if (pm_addr !== 8'h05) begin errors++; $display("FAIL bp_pre_pm got %h exp 05", pm_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL bp_pre_halt got %b exp 0", halted); end
        tick();
        checks++; if ({halted, stall} !== 2'b11) begin errors++; $display("FAIL bp_halt got %b exp 11", {halted, stall}); end
        checks++; if (pc !== 8'h05) begin errors++; $display("FAIL bp_pc got %h exp 05", pc); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (pm_addr !== 8'h05) begin errors++; $display("FAIL bp_hold_pm[%0d] got %h exp 05", i, pm_addr); end
            checks++; if (instr_count !== 16'd6) begin errors++; $display("FAIL bp_hold_cnt[%0d] got %0d exp 6", i, instr_count); end
        end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        checks++; if ({halted, stall} !== 2'b00) begin errors++; $display("FAIL step_run got %b exp 00", {halted, stall}); end
        checks++; if (pm_addr !== 8'h06) begin errors++; $display("FAIL step_pm got %h exp 06", pm_addr); end
        tick();
        checks++; if ({halted, stall} !== 2'b11) begin errors++; $display("FAIL step_rehalt got %b exp 11", {halted, stall}); end
        checks++; if (pc !== 8'h06) begin errors++; $display("FAIL step_pc got %h exp 06", pc); end
        checks++; if (instr_count !== 16'd7) begin errors++; $display("FAIL step_cnt got %0d exp 7", instr_count); end
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL step_once got %b exp 1", stall); end
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL resume_stall got %b exp 0", stall); end
        checks++; if (pm_addr !== 8'h07) begin errors++; $display("FAIL resume_pm got %h exp 07", pm_addr); end
        tick();
        checks++; if (pc !== 8'h07) begin errors++; $display("FAIL resume_pc got %h exp 07", pc); end
        bp_en = 1'b0;
    endtask

    task automatic test_halt_jump();
        jmp = 1'b1; ir_nibble = 4'h3; halt_req = 1'b1;
        #1;
        checks++; if (pm_addr !== 8'h30) begin errors++; $display("FAIL hj_pm got %h exp 30", pm_addr); end
        tick();
        halt_req = 1'b0; ir_nibble = 4'h7;
        #1;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hj_halt got %b exp 1", halted); end
        checks++; if (pc !== 8'h30) begin errors++; $display("FAIL hj_pc got %h exp 30", pc); end
        checks++; if (pm_addr !== 8'h30) begin errors++; $display("FAIL hj_ignored_pm got %h exp 30", pm_addr); end
        tick();
        jmp = 1'b0;
        checks++; if (pc !== 8'h30) begin errors++; $display("FAIL hj_hold_pc got %h exp 30", pc); end
    endtask

    task automatic test_sync_reset();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL clr_halted got %0d exp 0", instr_count); end
        resume_req = 1'b1; step_req = 1'b1;
        tick();
        resume_req = 1'b0; step_req = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rs_both got %b exp 0", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rs_resume_wins got %b exp 0", stall); end
        checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL rs_cnt got %0d exp 1", instr_count); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL sr_pre_halt got %b exp 1", halted); end
        sync_reset = 1'b1;
        #1;
        checks++; if (pm_addr !== 8'h00) begin errors++; $display("FAIL sr_halt_pm got %h exp 00", pm_addr); end
        tick();
        sync_reset = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL sr_run got %b exp 0", halted); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL sr_pc got %h exp 00", pc); end
        checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL sr_cnt_kept got %0d exp 2", instr_count); end
        checks++; if (pm_addr !== 8'h01) begin errors++; $display("FAIL sr_next_pm got %h exp 01", pm_addr); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL clr_prio got %0d exp 0", instr_count); end
    endtask

    task automatic test_async_reset();
        repeat (3) tick();
        checks++; if (pc !== 8'h04) begin errors++; $display("FAIL ar_pre_pc got %h exp 04", pc); end
        checks++; if (instr_count !== 16'd3) begin errors++; $display("FAIL ar_pre_cnt got %0d exp 3", instr_count); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL ar_pc got %h exp 00", pc); end
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", instr_count); end
        checks++; if (pm_addr !== 8'h00) begin errors++; $display("FAIL ar_pm got %h exp 00", pm_addr); end
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_increment();
        test_jump();
        test_cond_jump();
        test_breakpoint();
        test_halt_jump();
        test_sync_reset();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
